// File: rtl/mapper_ss_engine.sv
// rtl/mapper_ss_engine.sv - save-state transfer engine driving the mapper save-state bus
module mapper_ss_engine #(
    parameter int SS_LEN   = 128,
    parameter int IDX_ADDR = 127
) (
    input  logic       m2,
    input  logic       map_rst,
    input  logic       start,
    input  logic       dir,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] buf_addr,
    output logic [7:0] buf_wdat,
    output logic       buf_we,
    input  logic [7:0] buf_rdat,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_wdat,
    input  logic [7:0] ss_rdat
);

    typedef enum logic [3:0] {
        IDLE, S_ADDR, S_STORE, R_IDXF, R_IDXC, R_FETCH, R_WRITE, DONE, ERR
    } state_t;

    localparam logic [7:0] LAST     = 8'(SS_LEN - 1);
    localparam logic [7:0] IDX      = 8'(IDX_ADDR);
    localparam logic [7:0] FIRST_WR = (IDX_ADDR == 0) ? 8'd1 : 8'd0;

    state_t     state;
    logic [7:0] a;
    logic [7:0] a_inc;
    logic [7:0] a_next_wr;
    logic       last_wr;

    // Restore never writes the index address, so the walk hops over it.
    always_comb begin
        a_inc     = a + 8'd1;
        a_next_wr = (a_inc == IDX) ? a + 8'd2 : a_inc;
        last_wr   = (a == LAST) || ((a_inc == IDX) && (a_inc == LAST));
    end

    always_ff @(posedge m2) begin
        if (map_rst) begin
            state    <= IDLE;
            a        <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            buf_addr <= 8'd0;
            buf_wdat <= 8'd0;
            buf_we   <= 1'b0;
            ss_act   <= 1'b0;
            ss_we    <= 1'b0;
            ss_addr  <= 8'd0;
            ss_wdat  <= 8'd0;
        end else begin
            done   <= 1'b0;
            buf_we <= 1'b0;
            ss_we  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        ss_act <= 1'b1;
                        a      <= 8'd0;
                        if (!dir) begin
                            state   <= S_ADDR;
                            ss_addr <= 8'd0;
                        end else begin
                            state    <= R_IDXF;
                            buf_addr <= IDX;
                            ss_addr  <= IDX;
                        end
                    end
                end
                S_ADDR: begin
                    state    <= S_STORE;
                    buf_addr <= a;
                    buf_wdat <= ss_rdat;
                    buf_we   <= 1'b1;
                end
                S_STORE: begin
                    if (a == LAST) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        ss_act <= 1'b0;
                    end else begin
                        state   <= S_ADDR;
                        a       <= a_inc;
                        ss_addr <= a_inc;
                    end
                end
                // Buffer reads lag the address by a cycle, so buf_addr runs one
                // step ahead of the write so ss_wdat can be registered.
                R_IDXF: begin
                    state    <= R_IDXC;
                    a        <= FIRST_WR;
                    buf_addr <= FIRST_WR;
                end
                R_IDXC: begin
                    if (buf_rdat != ss_rdat) begin
                        state  <= ERR;
                        err    <= 1'b1;
                        ss_act <= 1'b0;
                    end else begin
                        state <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    state    <= R_WRITE;
                    ss_addr  <= a;
                    ss_wdat  <= buf_rdat;
                    ss_we    <= 1'b1;
                    buf_addr <= a_next_wr;
                end
                R_WRITE: begin
                    if (last_wr) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        ss_act <= 1'b0;
                    end else begin
                        state <= R_FETCH;
                        a     <= a_next_wr;
                    end
                end
                DONE, ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mapper_ss_engine.md
# mapper_ss_engine

Save-state transfer engine: the initiator side of the mapper save-state bus. On request it walks the mapper's save-state address space. It either dumps every register byte into a host-side state buffer (save) or writes buffer bytes back into the mapper (restore). It sits between the cartridge system controller and the active mapper module, and drives the mapper's `ss_act`/`ss_we`/`ss_addr`/data inputs.

## Interface
- `SS_LEN`, 128: number of save-state addresses walked (0 .. SS_LEN-1).
- `IDX_ADDR`, 127: address holding the read-only mapper index byte.

- `m2`  in  1  clock; all state updates on rising edge. Mapper samples on falling edge.
- `map_rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `dir`  in  1  sampled with `start`: 0 = save, 1 = restore.
- `busy`  out  1  high from the cycle after accepted `start` until DONE/ERR exits.
- `done`  out  1  one-cycle pulse on successful completion.
- `err`  out  1  sticky; set on index mismatch, cleared by next accepted `start`.
- `buf_addr`  out  8  state buffer address.
- `buf_wdat`  out  8  state buffer write data.
- `buf_we`  out  1  state buffer write strobe.
- `buf_rdat`  in  8  state buffer read data, valid one cycle after `buf_addr`.
- `ss_act`  out  1  save-state mode to mapper.
- `ss_we`  out  1  save-state write strobe to mapper.
- `ss_addr`  out  8  save-state address to mapper.
- `ss_wdat`  out  8  write data to mapper, driven onto the `cpu_dat` path.
- `ss_rdat`  in  8  mapper readback; combinational from `ss_addr`.

## Operation
- States: IDLE, S_ADDR, S_STORE, R_IDXF, R_IDXC, R_FETCH, R_WRITE, DONE, ERR.
- IDLE: `start`=1 latches `dir` and clears `err`. The 8-bit counter `a` is set to 0. Next state is S_ADDR if `dir`=0, else R_IDXF.
- Save:
  - S_ADDR: `ss_addr`=a, `ss_we`=0.
  - S_STORE: `buf_addr`=a, `buf_wdat`=`ss_rdat`, `buf_we`=1.
  - If a==SS_LEN-1, go to DONE. Otherwise a+1 and return to S_ADDR.
- Restore index check:
  - R_IDXF: `buf_addr`=IDX_ADDR, `ss_addr`=IDX_ADDR.
  - R_IDXC: compare `buf_rdat` with `ss_rdat`. Mismatch goes to ERR with no mapper writes. Match goes to R_FETCH with a=0.
- Restore loop:
  - R_FETCH: `buf_addr`=a.
  - R_WRITE: `ss_addr`=a, `ss_wdat`=`buf_rdat`, `ss_we`=1 for exactly this cycle.
  - If a==IDX_ADDR, skip both states: no write to the index address.
  - After a==SS_LEN-1, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE. ERR: `err`=1, then IDLE.
- `ss_act`=1 in every state except IDLE, DONE and ERR.
- `start` while not IDLE is ignored.
- `a` is 8-bit and never wraps; the terminal compare is against SS_LEN-1.

## Timing
- Reset values: `busy`, `done`, `err`, `buf_we`, `ss_act`, `ss_we` = 0. `buf_addr`, `ss_addr`, `buf_wdat`, `ss_wdat` = 0. State = IDLE.
- All outputs are registered and change only on the rising edge of `m2`. This gives the mapper half a cycle of setup before its falling-edge sample.
- Save latency: 2·SS_LEN cycles from the first S_ADDR to DONE. `done` occurs at start+2·SS_LEN+1.
- Restore latency: 2 cycles for the index check, plus 2·(SS_LEN-1) cycles of writes, then DONE.
- `ss_we` is never high in consecutive cycles. `ss_addr`/`ss_wdat` are stable for the whole cycle `ss_we` is high.
- `map_rst` mid-transfer: next edge forces IDLE and all outputs to reset values. `ss_act` drops immediately. Mapper writes already issued are not undone, and no `done` is produced.
- `start` in the same cycle as `map_rst`: reset wins; the request is lost.

## Test plan
- Save with a mapper model returning 0x5A at addr 0, the index 0x68 at 127, and 0xFF elsewhere. Required: buffer[0]=0x5A, buffer[127]=0x68, all others 0xFF. `done` occurs exactly 257 cycles after `start`.
- Restore with buffer[0]=0x3C and a matching index. Required: the mapper sees `ss_we` at addr 0 with 0x3C. 127 `ss_we` pulses total, none at addr 127. `done` pulses once and `err`=0.
- Restore with buffer[127]=0x01 and mapper index 0x68. Required: zero `ss_we` pulses, `err`=1 two cycles after the transfer begins, no `done`. The next accepted `start` clears `err`.
- Assert `map_rst` at restore address 40. Required: next cycle `ss_act`=0, `busy`=0, no further `ss_we`, no `done`.
- Pulse `start` repeatedly during a save. Required: ignored, with a single `done` at the normal time. `start` coincident with `map_rst` is required to leave the engine IDLE.
